// File: rtl/alu_cmd_issuer.sv
// Command front-end for the registered 4-bit ALU: buffers {A, B, op} in a FIFO, issues one per cycle,
// and tracks each issued command through the fixed ALU latency to return a tagged result.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic                     issue_en,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_op,
  output logic                     issue_valid,
  input  logic [7:0]               alu_out,
  output logic                     res_valid,
  output logic [7:0]               res_data,
  output logic [1:0]               res_op,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = 3 + TAG_W;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } cmd_t;

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } trk_t;

  cmd_t                mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count_nxt;
  logic [TAG_W-1:0]    tag_cnt;
  logic [TAG_W-1:0]    issue_tag;
  logic [ALU_LAT*TW-1:0] trk_q;
  logic                push_c;
  logic                pop_c;
  cmd_t                head_c;
  trk_t                trk_in_c;
  trk_t                trk_out_c;

  assign push_c    = cmd_valid & cmd_ready;
  assign pop_c     = issue_en & (fifo_count != '0);
  assign head_c    = mem[rd_ptr];
  assign trk_in_c  = '{vld: issue_valid, op: alu_op, tag: issue_tag};
  assign trk_out_c = trk_t'(trk_q[ALU_LAT*TW-1 -: TW]);

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = fifo_count;
    if (push_c && !pop_c) begin
      count_nxt = fifo_count + CW'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = fifo_count - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      cmd_ready   <= 1'b1;
      tag_cnt     <= '0;
      issue_tag   <= '0;
      issue_valid <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      trk_q       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_tag     <= '0;
    end else begin
      fifo_count  <= count_nxt;
      cmd_ready   <= (count_nxt < CW'(DEPTH));
      issue_valid <= pop_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr    <= rd_ptr + PW'(1);
        alu_a     <= head_c.a;
        alu_b     <= head_c.b;
        alu_op    <= head_c.op;
        issue_tag <= tag_cnt;
        tag_cnt   <= tag_cnt + TAG_W'(1);
      end
      // Newest stage in the low bits; the oldest drops off the top.
      trk_q     <= (ALU_LAT*TW)'({trk_q, trk_in_c});
      res_valid <= trk_out_c.vld;
      if (trk_out_c.vld) begin
        res_data <= alu_out;
        res_op   <= trk_out_c.op;
        res_tag  <= trk_out_c.tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: hand-computed vector table plus reset, full-FIFO and wrap sequences.
module tb_alu_cmd_issuer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic             issue_en;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_op;
  logic             issue_valid;
  logic [7:0]       alu_out;
  logic             res_valid;
  logic [7:0]       res_data;
  logic [1:0]       res_op;
  logic [TAG_W-1:0] res_tag;
  logic [2:0]       fifo_count;
  logic [7:0]       alu_s1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]       data;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } res_t;

  vec_t vecs [26];
  res_t got [$];
  int   iss [$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  alu_cmd_issuer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .issue_en(issue_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .issue_valid(issue_valid),
    .alu_out(alu_out), .res_valid(res_valid), .res_data(res_data),
    .res_op(res_op), .res_tag(res_tag), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream registered ALU: two register stages.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    alu_fn = 8'(a) + 8'(b);
      2'd1:    alu_fn = 8'(a) * 8'(b);
      2'd2:    alu_fn = 8'(a | b);
      default: alu_fn = 8'(a & b);
    endcase
  endfunction

  always @(posedge clk) begin
    alu_s1  <= alu_fn(alu_a, alu_b, alu_op);
    alu_out <= alu_s1;
    cyc     <= cyc + 1;
  end

  always @(negedge clk) begin
    if (res_valid) got.push_back('{res_data, res_op, res_tag, cyc});
    if (issue_valid) iss.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    issue_en  = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got.delete();
    iss.delete();
  endtask

  // Holds the command until a negedge sample of cmd_ready guarantees acceptance at the next edge.
  task automatic push(input int idx);
    int   k;
    logic ok;
    cmd_valid = 1'b1;
    cmd_a     = vecs[idx].a;
    cmd_b     = vecs[idx].b;
    cmd_op    = vecs[idx].op;
    k = 0;
    do begin
      ok = cmd_ready;
      @(negedge clk);
      k++;
    end while (!ok && k < 200);
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("result_count", 32'(got.size()), 32'(n));
  endtask

  task automatic compare_results(input int base, input int n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check("res_data", 32'(got[i].data), 32'(vecs[base+i].exp));
      check("res_op",   32'(got[i].op),   32'(vecs[base+i].op));
      check("res_tag",  32'(got[i].tag),  32'(i % 16));
    end
  endtask

  initial begin
    int p;
    // Back-to-back / full-FIFO vectors
    vecs[0]  = '{4'd15, 4'd15, 2'd0, 8'd30};
    vecs[1]  = '{4'd15, 4'd15, 2'd1, 8'd225};
    vecs[2]  = '{4'd12, 4'd10, 2'd2, 8'd14};
    vecs[3]  = '{4'd12, 4'd10, 2'd3, 8'd8};
    // Wrap vectors
    vecs[4]  = '{4'd1,  4'd2,  2'd0, 8'd3};
    vecs[5]  = '{4'd3,  4'd4,  2'd1, 8'd12};
    vecs[6]  = '{4'd5,  4'd6,  2'd2, 8'd7};
    vecs[7]  = '{4'd7,  4'd8,  2'd3, 8'd0};
    vecs[8]  = '{4'd9,  4'd9,  2'd0, 8'd18};
    vecs[9]  = '{4'd15, 4'd2,  2'd1, 8'd30};
    vecs[10] = '{4'd10, 4'd5,  2'd2, 8'd15};
    vecs[11] = '{4'd14, 4'd7,  2'd3, 8'd6};
    vecs[12] = '{4'd8,  4'd8,  2'd0, 8'd16};
    vecs[13] = '{4'd6,  4'd7,  2'd1, 8'd42};
    vecs[14] = '{4'd12, 4'd3,  2'd2, 8'd15};
    vecs[15] = '{4'd13, 4'd11, 2'd3, 8'd9};
    vecs[16] = '{4'd0,  4'd15, 2'd0, 8'd15};
    vecs[17] = '{4'd15, 4'd0,  2'd1, 8'd0};
    vecs[18] = '{4'd9,  4'd6,  2'd2, 8'd15};
    vecs[19] = '{4'd15, 4'd15, 2'd3, 8'd15};
    vecs[20] = '{4'd11, 4'd13, 2'd0, 8'd24};
    vecs[21] = '{4'd13, 4'd13, 2'd1, 8'd169};
    vecs[22] = '{4'd4,  4'd1,  2'd2, 8'd5};
    vecs[23] = '{4'd6,  4'd3,  2'd3, 8'd2};
    // Single-command and post-reset vectors
    vecs[24] = '{4'd3,  4'd5,  2'd1, 8'd15};
    vecs[25] = '{4'd2,  4'd3,  2'd0, 8'd5};

    // Reset held with cmd_valid high
    rst = 1'b0; cmd_valid = 1'b1; issue_en = 1'b1;
    cmd_a = 4'd9; cmd_b = 4'd9; cmd_op = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_fifo_count",  32'(fifo_count),  32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_res_valid",   32'(res_valid),   32'd0);
    check("rst_alu_a",       32'(alu_a),       32'd0);
    check("rst_alu_b",       32'(alu_b),       32'd0);
    check("rst_alu_op",      32'(alu_op),      32'd0);
    check("rst_res_data",    32'(res_data),    32'd0);
    check("rst_res_op",      32'(res_op),      32'd0);
    check("rst_res_tag",     32'(res_tag),     32'd0);

    // Single command: issue one cycle after push, result three cycles after issue
    do_reset();
    issue_en = 1'b1;
    p = cyc;
    push(24);
    cmd_valid = 1'b0;
    check("single_count",    32'(fifo_count),  32'd1);
    check("single_iv_early", 32'(issue_valid), 32'd0);
    @(negedge clk);
    check("single_issue_valid", 32'(issue_valid), 32'd1);
    check("single_alu_a",  32'(alu_a),  32'd3);
    check("single_alu_b",  32'(alu_b),  32'd5);
    check("single_alu_op", 32'(alu_op), 32'd1);
    @(negedge clk);
    check("single_iv_drop", 32'(issue_valid), 32'd0);
    check("single_alu_hold", 32'(alu_a), 32'd3);
    wait_results(1, 10);
    compare_results(24, 1);
    if (got.size() >= 1 && iss.size() >= 1) begin
      check("single_issue_lat", 32'(iss[0] - p), 32'd2);
      check("single_res_lat", 32'(got[0].cyc - iss[0]), 32'd3);
    end

    // Back-to-back pushes with simultaneous issue
    do_reset();
    issue_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(i);
      if (i == 2) check("b2b_count_steady", 32'(fifo_count), 32'd1);
    end
    cmd_valid = 1'b0;
    wait_results(4, 20);
    compare_results(0, 4);
    for (int i = 1; i < 4 && i < got.size(); i++)
      check("b2b_consecutive", 32'(got[i].cyc - got[0].cyc), 32'(i));

    // Full FIFO: fifth command refused until a slot frees
    do_reset();
    for (int i = 0; i < 4; i++) push(i);
    cmd_valid = 1'b1;
    cmd_a = vecs[4].a; cmd_b = vecs[4].b; cmd_op = vecs[4].op;
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    repeat (2) @(negedge clk);
    check("full_no_push", 32'(fifo_count), 32'd4);
    cmd_valid = 1'b0;
    issue_en = 1'b1;
    @(negedge clk);
    check("full_first_count", 32'(fifo_count), 32'd3);
    check("full_ready_back", 32'(cmd_ready), 32'd1);
    check("full_first_issue", 32'(issue_valid), 32'd1);
    check("full_first_alu_a", 32'(alu_a), 32'd15);
    wait_results(4, 20);
    compare_results(0, 4);
    repeat (5) @(negedge clk);
    check("full_no_extra", 32'(got.size()), 32'd4);

    // Wrap: 20 commands with issue_en toggling every 3 cycles
    do_reset();
    issue_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) push(4 + i);
        cmd_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (k % 3 == 2) issue_en = ~issue_en;
        end
        issue_en = 1'b1;
      end
    join
    wait_results(20, 40);
    compare_results(4, 20);

    // Reset one cycle after an issue, with another command still queued
    do_reset();
    issue_en = 1'b1;
    push(24);
    push(25);
    cmd_valid = 1'b0;
    issue_en = 1'b0;
    check("mid_issue", 32'(issue_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_iv", 32'(issue_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_no_res", 32'(got.size()), 32'd0);
    check("mid_empty", 32'(fifo_count), 32'd0);
    issue_en = 1'b1;
    push(25);
    cmd_valid = 1'b0;
    wait_results(1, 10);
    if (got.size() >= 1) begin
      check("mid_post_tag",  32'(got[0].tag),  32'd0);
      check("mid_post_data", 32'(got[0].data), 32'd5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
